// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the CPU execution controller.
//   state_t           FSM state encoding, also driven onto the 3-bit state port
//   DEFAULT_STEP_DIV  clk_50m cycles between run-mode steps (2 Hz at 50 MHz)
//   EXEC_CNT_W/MAX    width and saturation value of the executed-instruction count
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FETCH = 3'd3,
    ST_EXEC  = 3'd4
  } state_t;

  localparam int DEFAULT_STEP_DIV = 25_000_000;

  localparam int                  EXEC_CNT_W   = 16;
  localparam logic [EXEC_CNT_W-1:0] EXEC_CNT_MAX = '1;

endpackage

// File: rtl/cpu_exec_ctrl_step_timer.sv
// step_timer
// Free-running step divider for run mode. While enabled it counts
// 0 .. STEP_DIV-1 and flags tick during the terminal count cycle, then wraps.
// clear forces the count back to zero and takes precedence over enable.
//   clk_50m  in   clock
//   rst      in   asynchronous active-high reset
//   clear    in   synchronous clear of the count
//   enable   in   count enable
//   tick     out  high in the cycle the count sits at STEP_DIV-1 (while enabled)
module step_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int STEP_DIV = DEFAULT_STEP_DIV
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int               CNT_W    = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = enable && !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl
// Execution controller sitting between a program loader, an instruction
// memory and a simple CPU. Holds the CPU in reset until a program is loaded,
// then single-steps it on command or free-runs it at one instruction per
// STEP_DIV clocks, with an optional address breakpoint.
//   clk_50m, rst        clock, asynchronous active-high reset
//   load_done           level, program valid; low forces IDLE
//   run_req/halt_req/step_req  one-cycle command pulses (halt > run > step)
//   bp_en, bp_addr      breakpoint enable and address
//   cpu_addr            CPU program counter
//   mem_addr/mem_data   instruction memory read port (data one cycle later)
//   cpu_instr, cpu_step latched instruction and one-cycle advance strobe
//   cpu_rst             CPU reset, high in IDLE
//   state, exec_cnt, bp_hit  status
module cpu_exec_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int STEP_DIV = DEFAULT_STEP_DIV,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  load_done,
  input  logic                  run_req,
  input  logic                  halt_req,
  input  logic                  step_req,
  input  logic                  bp_en,
  input  logic [ADDR_W-1:0]     bp_addr,
  input  logic [ADDR_W-1:0]     cpu_addr,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic [DATA_W-1:0]     cpu_instr,
  output logic                  cpu_step,
  output logic                  cpu_rst,
  output logic [2:0]            state,
  output logic [EXEC_CNT_W-1:0] exec_cnt,
  output logic                  bp_hit
);

  state_t cur_state, next_state;

  // run_mode: free-running (as opposed to a single step), kept through FETCH/EXEC
  // pend_halt: halt requested while an instruction was in flight
  // bp_skip: suppresses the breakpoint compare on the first tick after HALT
  logic run_mode, run_mode_next;
  logic pend_halt, pend_halt_next;
  logic bp_skip, bp_skip_next;
  logic bp_hit_next;
  logic tick;
  logic bp_match;

  // The divider keeps counting through FETCH/EXEC so run-mode steps stay on
  // a fixed STEP_DIV grid; it is held cleared whenever we are not running,
  // which makes the first tick land exactly STEP_DIV cycles after run_req.
  step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clk_50m (clk_50m),
    .rst     (rst),
    .clear   (!run_mode),
    .enable  (run_mode),
    .tick    (tick)
  );

  assign bp_match = bp_en && (cpu_addr == bp_addr) && !bp_skip;

  always_comb begin
    next_state     = cur_state;
    run_mode_next  = run_mode;
    pend_halt_next = pend_halt;
    bp_skip_next   = bp_skip;
    bp_hit_next    = bp_hit;

    unique case (cur_state)
      ST_IDLE: begin
        run_mode_next  = 1'b0;
        pend_halt_next = 1'b0;
        bp_skip_next   = 1'b0;
        bp_hit_next    = 1'b0;
        if (load_done) begin
          next_state = ST_HALT;
        end
      end

      ST_HALT: begin
        // halt_req in HALT is a no-op but still masks a simultaneous run/step
        if (!halt_req) begin
          if (run_req) begin
            next_state    = ST_RUN;
            run_mode_next = 1'b1;
            bp_skip_next  = 1'b1;
            bp_hit_next   = 1'b0;
          end else if (step_req) begin
            next_state    = ST_FETCH;
            run_mode_next = 1'b0;
            bp_skip_next  = 1'b1;
            bp_hit_next   = 1'b0;
          end
        end
      end

      ST_RUN: begin
        if (halt_req) begin
          next_state    = ST_HALT;
          run_mode_next = 1'b0;
        end else if (tick) begin
          bp_skip_next = 1'b0;
          if (bp_match) begin
            next_state    = ST_HALT;
            run_mode_next = 1'b0;
            bp_hit_next   = 1'b1;
          end else begin
            next_state = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        next_state = ST_EXEC;
        if (halt_req) begin
          pend_halt_next = 1'b1;
        end
      end

      ST_EXEC: begin
        if (run_mode && !pend_halt && !halt_req) begin
          next_state = ST_RUN;
        end else begin
          next_state     = ST_HALT;
          run_mode_next  = 1'b0;
          pend_halt_next = 1'b0;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase

    // Losing the program overrides everything, including an in-flight step.
    if (!load_done) begin
      next_state     = ST_IDLE;
      run_mode_next  = 1'b0;
      pend_halt_next = 1'b0;
      bp_skip_next   = 1'b0;
      bp_hit_next    = 1'b0;
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      cur_state <= ST_IDLE;
      run_mode  <= 1'b0;
      pend_halt <= 1'b0;
      bp_skip   <= 1'b0;
      bp_hit    <= 1'b0;
    end else begin
      cur_state <= next_state;
      run_mode  <= run_mode_next;
      pend_halt <= pend_halt_next;
      bp_skip   <= bp_skip_next;
      bp_hit    <= bp_hit_next;
    end
  end

  // Outputs are decoded from next_state and registered, so every output
  // changes on a clock edge and tracks the state it belongs to. The address
  // is captured on entry to FETCH and the instruction on entry to EXEC.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      cpu_instr <= '0;
      cpu_step  <= 1'b0;
      cpu_rst   <= 1'b1;
      exec_cnt  <= '0;
    end else begin
      cpu_step <= (next_state == ST_EXEC);
      cpu_rst  <= (next_state == ST_IDLE);
      if (next_state == ST_FETCH) begin
        mem_addr <= cpu_addr;
      end
      if (next_state == ST_EXEC) begin
        cpu_instr <= mem_data;
      end
      if (next_state == ST_IDLE) begin
        exec_cnt <= '0;
      end else if (cpu_step && (exec_cnt != EXEC_CNT_MAX)) begin
        exec_cnt <= exec_cnt + EXEC_CNT_W'(1);
      end
    end
  end

  assign state = cur_state;

endmodule

// File: doc/cpu_exec_ctrl.md
CPU_EXEC_CTRL -- requirements
Module: cpu_exec_ctrl

Interface
REQ-001 SHALL have parameter STEP_DIV, default 25_000_000, clk_50m cycles between run-mode steps (2 Hz at 50 MHz); legal minimum 4.
REQ-002 SHALL have parameter ADDR_W, default 8, instruction memory address width.
REQ-003 SHALL have parameter DATA_W, default 8, instruction width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk_50m input, rst input.
REQ-005 clk_50m  in  1  sole clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 load_done  in  1  level; high while a loaded program is valid.
REQ-008 run_req / halt_req / step_req  in  1 each  one-cycle command pulses.
REQ-009 bp_en  in  1  breakpoint enable.
REQ-010 bp_addr  in  ADDR_W  breakpoint address.
REQ-011 cpu_addr  in  ADDR_W  CPU program-counter address.
REQ-012 mem_addr  out  ADDR_W  registered instruction memory read address.
REQ-013 mem_data  in  DATA_W  memory read data, valid one cycle after mem_addr.
REQ-014 cpu_instr  out  DATA_W  latched instruction presented to the CPU.
REQ-015 cpu_step  out  1  one-cycle CPU advance strobe.
REQ-016 cpu_rst  out  1  CPU reset, active-high.
REQ-017 state  out  3  current FSM state encoding.
REQ-018 exec_cnt  out  16  executed-instruction count.
REQ-019 bp_hit  out  1  sticky; high while halted by the breakpoint.

Function
REQ-020 SHALL implement states IDLE, HALT, RUN, FETCH, EXEC.
REQ-021 IDLE: cpu_rst=1; advances to HALT in the cycle after load_done is sampled high.
REQ-022 HALT: cpu_rst=0; run_req -> RUN; step_req -> FETCH (single step, returns to HALT).
REQ-023 RUN: the divider counts from 0 and issues a tick when it reaches STEP_DIV-1; the tick enters FETCH.
REQ-024 Entry to RUN clears the divider, so the first tick is exactly STEP_DIV cycles after the run_req cycle.
REQ-025 FETCH (1 cycle): mem_addr <= cpu_addr.
REQ-026 EXEC (1 cycle): cpu_instr <= mem_data on entry; cpu_step=1 only in EXEC.
REQ-027 EXEC exit: to RUN if running and no pending halt, else to HALT.
REQ-028 Latency: cpu_step is asserted 2 cycles after the tick or the step_req cycle.
REQ-029 Breakpoint: at a RUN tick with bp_en=1 and cpu_addr==bp_addr, go to HALT (no fetch) and set bp_hit.
REQ-030 bp_hit clears on the next run_req or step_req.
REQ-031 The first tick after leaving HALT skips the breakpoint compare, so resume does not re-trigger it.
REQ-032 Command priority for simultaneous pulses: halt_req > run_req > step_req.
REQ-033 Commands in IDLE are ignored.
REQ-034 run_req while in RUN is ignored and does not restart the divider.
REQ-035 halt_req in FETCH/EXEC is latched; the in-flight instruction completes (cpu_step issued), then HALT.
REQ-036 step_req in RUN/FETCH/EXEC is ignored.
REQ-037 load_done low in any state -> IDLE next cycle; an in-flight cpu_step is suppressed; cpu_rst=1.
REQ-038 exec_cnt increments once per cpu_step, saturates at 0xFFFF, and clears on entry to IDLE.
REQ-039 mem_addr, cpu_instr and cpu_step SHALL be registered outputs; no combinational path from inputs to outputs.

Reset
REQ-040 On rst: state=IDLE, cpu_rst=1, cpu_step=0, mem_addr=0, cpu_instr=0, exec_cnt=0, bp_hit=0, divider=0, pending-halt=0, bp-skip=0.
REQ-041 rst asserted mid-FETCH/EXEC SHALL abort without a cpu_step pulse.
REQ-042 Reset release SHALL be the only asynchronous event; all other transitions occur on clk_50m rising edges.

Structure
REQ-043 Shared package cpu_ctrl_pkg SHALL hold the state encodings (IDLE=0, HALT=1, RUN=2, FETCH=3, EXEC=4) and the default STEP_DIV.
REQ-044 Sub-module step_timer SHALL implement the divider: ports clear and enable in, tick out, parameter STEP_DIV.
REQ-045 The FSM, breakpoint compare and counters SHALL reside in cpu_exec_ctrl.

Verification (STEP_DIV=4 on the bench)
REQ-046 rst, then load_done=1 -> state IDLE->HALT, cpu_rst falls 1 cycle after load_done is sampled high, exec_cnt=0.
REQ-047 HALT, step_req with cpu_addr=0x05 and mem_data=0xA3 -> mem_addr=0x05 next cycle; cpu_step high with cpu_instr=0xA3 2 cycles after step_req; state HALT; exec_cnt=1.
REQ-048 run_req, hold 20 cycles -> cpu_step pulses at cycles 6, 10, 14, 18 after run_req; exec_cnt=4.
REQ-049 RUN with bp_en=1, bp_addr=0x03, cpu_addr reaching 0x03 -> HALT, bp_hit=1, no cpu_step; run_req -> bp_hit=0 and the next tick fetches 0x03.
REQ-050 halt_req and run_req in the same cycle during FETCH -> EXEC pulse still issued, then HALT.
REQ-051 load_done dropped during FETCH -> no cpu_step, state IDLE next cycle, cpu_rst=1, exec_cnt cleared.
